axis_cic_decimator: RTL and testbench

Receive-side counterpart to the MASH 1-1 modulator. Accepts the signed multi-bit MASH code stream over AXI-Stream and reconstructs PCM samples with an N-stage CIC decimator (differential delay 1). Outputs one signed sample per R accepted inputs over AXI-Stream with backpressure. It is the loopback and verification path for the DAC chain: NCO, then MASH, then this block.

---
 rtl/axis_cic_decimator_pkg.sv | 18 +
 rtl/axis_cic_decimator_if.sv | 16 +
 rtl/axis_cic_decimator_comb_stage.sv | 34 +++
 rtl/axis_cic_decimator.sv | 125 ++++++++++++
 tb/tb_axis_cic_decimator.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_cic_decimator_pkg.sv
// Shared constants and width helpers for the CIC decimator.
//   acc_width : internal modular width IN_BW + ORDER*log2(R)
//   out_shift : right-shift from internal width to output width
//               (negative result means a left shift is needed)
package cic_dec_pkg;

  localparam int MAX_ORDER = 5;
  localparam int MIN_R     = 4;

  function automatic int acc_width(input int in_bw, input int order, input int r);
    return in_bw + order * $clog2(r);
  endfunction

  function automatic int out_shift(input int acc_w, input int out_w);
    return acc_w - out_w;
  endfunction

endpackage

// File: rtl/axis_cic_decimator_if.sv
// AXI-Stream bundle used for both the MASH code input and the PCM output.
//   tdata  : payload, W bits
//   tvalid : source has data
//   tready : sink can take data
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; a source keeps tvalid and tdata stable until that happens.
interface axis_cic_decimator_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_cic_decimator_comb_stage.sv
// One CIC comb section with differential delay 1.
//   clk, rst   : clock, synchronous active-high reset
//   strobe_in  : new value present on c_in
//   c_in       : value from previous stage (or the decimated integrator)
//   strobe_out : strobe_in delayed one cycle, marks c_out as fresh
//   c_out      : registered c_in - (previous c_in), modular at W bits
module cic_comb_stage #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe_in,
  input  logic [W-1:0] c_in,
  output logic         strobe_out,
  output logic [W-1:0] c_out
);

  logic [W-1:0] z;

  always_ff @(posedge clk) begin
    if (rst) begin
      z          <= '0;
      c_out      <= '0;
      strobe_out <= 1'b0;
    end else begin
      strobe_out <= strobe_in;
      if (strobe_in) begin
        c_out <= c_in - z;
        z     <= c_in;
      end
    end
  end

endmodule

// File: rtl/axis_cic_decimator.sv
// N-stage CIC decimator (differential delay 1) turning the MASH code stream
// back into PCM samples, one output per R accepted inputs.
//   aclk, arst  : clock, synchronous active-high reset
//   s_axis_data : slave stream, signed IN_BW-bit MASH codes
//   m_axis_data : master stream, signed OUT_WIDTH-bit decimated samples
// Input is stalled only while an output sample waits for its consumer, which
// freezes the integrators and the decimation counter so nothing is lost.
module axis_cic_decimator
  import cic_dec_pkg::*;
#(
  parameter int IN_BW     = 4,
  parameter int OUT_WIDTH = 16,
  parameter int R         = 64,
  parameter int ORDER     = 3
) (
  input  logic aclk,
  input  logic arst,
  axis_cic_decimator_if.slave  s_axis_data,
  axis_cic_decimator_if.master m_axis_data
);

  localparam int ACC_W = acc_width(IN_BW, ORDER, R);
  localparam int SHIFT = out_shift(ACC_W, OUT_WIDTH);
  localparam int CNT_W = $clog2(R);

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] integ      [1:ORDER];
  logic [ACC_W-1:0] integ_next [1:ORDER];
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] d0;
  logic             d0_stb;
  logic [ACC_W-1:0] c   [0:ORDER];
  logic             stb [0:ORDER];
  logic [ORDER:0]   stb_vec;
  logic             accept;
  logic             land;
  logic             out_valid;

  assign x_ext  = {{(ACC_W - IN_BW){s_axis_data.tdata[IN_BW-1]}}, s_axis_data.tdata};
  assign s_axis_data.tready = !(out_valid && !m_axis_data.tready);
  assign accept = s_axis_data.tvalid && s_axis_data.tready;

  // Each stage adds the already-updated previous stage, so all stages move
  // together on one accept with no skew between them.
  always_comb begin
    integ_next[1] = integ[1] + x_ext;
    for (int k = 2; k <= ORDER; k++) begin
      integ_next[k] = integ[k] + integ_next[k-1];
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      for (int k = 1; k <= ORDER; k++) integ[k] <= '0;
      cnt    <= '0;
      d0     <= '0;
      d0_stb <= 1'b0;
    end else begin
      d0_stb <= 1'b0;
      if (accept) begin
        for (int k = 1; k <= ORDER; k++) integ[k] <= integ_next[k];
        if (cnt == CNT_W'(R - 1)) begin
          cnt    <= '0;
          d0     <= integ_next[ORDER];
          d0_stb <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign c[0]   = d0;
  assign stb[0] = d0_stb;

  for (genvar k = 1; k <= ORDER; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_stage (
      .clk        (aclk),
      .rst        (arst),
      .strobe_in  (stb[k-1]),
      .c_in       (c[k-1]),
      .strobe_out (stb[k]),
      .c_out      (c[k])
    );
  end

  // The last comb register doubles as the output data register: it only
  // changes when a new result lands, so tdata stays put while stalled.
  assign land = stb[ORDER-1];

  always_ff @(posedge aclk) begin
    if (arst) begin
      out_valid <= 1'b0;
    end else if (land) begin
      out_valid <= 1'b1;
    end else if (out_valid && m_axis_data.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign m_axis_data.tvalid = out_valid;

  if (SHIFT > 0) begin : g_shr
    assign m_axis_data.tdata = c[ORDER][ACC_W-1:SHIFT];
    logic unused_low;
    assign unused_low = ^c[ORDER][SHIFT-1:0];
  end else if (SHIFT == 0) begin : g_same
    assign m_axis_data.tdata = c[ORDER];
  end else begin : g_shl
    assign m_axis_data.tdata = {c[ORDER], {(-SHIFT){1'b0}}};
  end

  always_comb begin
    stb_vec = '0;
    for (int k = 0; k <= ORDER; k++) stb_vec[k] = stb[k];
  end

  // R > ORDER keeps at most one result in the comb pipe, and a result can
  // only land once the previous one has left, so the combs never stall.
  a_one_in_flight : assert property (@(posedge aclk) disable iff (arst)
    $onehot0(stb_vec));
  a_no_overwrite : assert property (@(posedge aclk) disable iff (arst)
    land |-> !(out_valid && !m_axis_data.tready));

endmodule

// File: tb/tb_axis_cic_decimator.sv
// Self-checking bench for axis_cic_decimator. Expected samples come from a
// direct FIR view of the CIC: the output after every R-th accepted sample is
// the accepted history convolved with (boxcar of length R)^ORDER, then
// arithmetically shifted down to the output width.
module tb_axis_cic_decimator;

  localparam int IN_BW = 4;
  localparam int OUT_W = 16;
  localparam int R     = 64;
  localparam int ORDER = 3;
  localparam int ACC_W = IN_BW + ORDER * $clog2(R);
  localparam int SHIFT = ACC_W - OUT_W;
  localparam int L     = ORDER * (R - 1) + 1;

  // clock / reset
  logic aclk = 1'b0;
  logic arst;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  axis_cic_decimator_if #(.W(IN_BW)) s_if ();
  axis_cic_decimator_if #(.W(OUT_W)) m_if ();

  axis_cic_decimator #(
    .IN_BW(IN_BW), .OUT_WIDTH(OUT_W), .R(R), .ORDER(ORDER)
  ) dut (
    .aclk        (aclk),
    .arst        (arst),
    .s_axis_data (s_if),
    .m_axis_data (m_if)
  );

  int tests = 0;
  int fails = 0;

  // reference model and scoreboard
  longint           h [0:L-1];
  int               acc_hist [$];
  logic [OUT_W-1:0] exp_q [$];
  logic [OUT_W-1:0] got_q [$];
  int               n_acc = 0;
  int               acc_r_edge = -1;
  int               rise_edge = -1;
  logic             prev_v = 1'b0;

  function automatic logic [OUT_W-1:0] model_out();
    longint acc = 0;
    int n = acc_hist.size();
    for (int j = 0; j < L; j++)
      if (n - 1 - j >= 0) acc += h[j] * longint'(acc_hist[n-1-j]);
    return OUT_W'(acc >>> SHIFT);
  endfunction

  // Monitor: inputs are stable from posedge+1 to the next posedge, so the
  // negedge view is exactly what the coming edge will transfer.
  always @(negedge aclk) begin
    if (arst) begin
      acc_hist.delete();
      exp_q.delete();
      got_q.delete();
      n_acc      = 0;
      acc_r_edge = -1;
      rise_edge  = -1;
      prev_v     = 1'b0;
    end else begin
      if (s_if.tvalid && s_if.tready) begin
        acc_hist.push_back(int'($signed(s_if.tdata)));
        n_acc++;
        if (n_acc == R) acc_r_edge = cyc + 1;
        if (n_acc % R == 0) exp_q.push_back(model_out());
      end
      if (m_if.tvalid && m_if.tready) got_q.push_back(m_if.tdata);
      if (m_if.tvalid && !prev_v && rise_edge < 0) rise_edge = cyc;
      prev_v = m_if.tvalid;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge aclk); #1;
    arst = 1'b1;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 arst = 1'b0;
  endtask

  // mode 0: constant value, mode 1: random codes. Stops after n accepts.
  task automatic drive(input int n, input int mode, input int value,
                       input int vld_pct, input int rdy_pct);
    int done = 0;
    int budget = n * 20 + 200;
    bit pend = 1'b0;
    while (done < n && budget > 0) begin
      @(posedge aclk); #1;
      if (!pend) begin
        s_if.tvalid = ($urandom_range(99) < vld_pct);
        s_if.tdata  = (mode == 0) ? IN_BW'(value) : IN_BW'($urandom_range(15));
      end
      m_if.tready = ($urandom_range(99) < rdy_pct);
      @(negedge aclk);
      if (s_if.tvalid && s_if.tready) done++;
      pend = s_if.tvalid && !s_if.tready;
      budget--;
    end
    tests++;
    if (done < n) begin
      fails++;
      $display("FAIL drive_budget accepted=%0d required=%0d", done, n);
    end
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
  endtask

  task automatic drain();
    repeat (ORDER + 6) @(posedge aclk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    @(negedge aclk);
    tests += 3;
    if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got=%b exp=0", m_if.tvalid); end
    if (m_if.tdata !== '0) begin fails++; $display("FAIL reset_tdata got=%h exp=0", m_if.tdata); end
    if (s_if.tready !== 1'b1) begin fails++; $display("FAIL reset_tready got=%b exp=1", s_if.tready); end
    @(posedge aclk); #1 arst = 1'b0;
    @(negedge aclk);
    tests += 2;
    if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL post_reset_tvalid got=%b exp=0", m_if.tvalid); end
    if (s_if.tready !== 1'b1) begin fails++; $display("FAIL post_reset_tready got=%b exp=1", s_if.tready); end
  endtask

  task automatic test_startup();
    logic [OUT_W-1:0] got;
    do_reset();
    drive(R, 0, 1, 100, 100);
    drain();
    tests += 4;
    if (got_q.size() != 1) begin fails++; $display("FAIL startup_count got=%0d exp=1", got_q.size()); end
    got = (got_q.size() > 0) ? got_q[0] : 'x;
    if (got !== OUT_W'(715)) begin fails++; $display("FAIL startup_value got=%0d exp=715", $signed(got)); end
    if (exp_q.size() > 0 && got !== exp_q[0]) begin fails++; $display("FAIL startup_model got=%0d exp=%0d", $signed(got), $signed(exp_q[0])); end
    if (rise_edge - acc_r_edge != ORDER) begin
      fails++;
      $display("FAIL startup_latency got=%0d exp=%0d", rise_edge - acc_r_edge, ORDER);
    end
  endtask

  // Constant input: every output matches the model, and from the third one
  // on the filter has settled to value * R^ORDER scaled to the output.
  task automatic test_constant(input string name, input int value,
                               input int n, input int settled);
    do_reset();
    drive(n, 0, value, 100, 100);
    drain();
    tests++;
    if (got_q.size() != n / R || exp_q.size() != n / R) begin
      fails++;
      $display("FAIL %s_count got=%0d model=%0d exp=%0d", name, got_q.size(), exp_q.size(), n / R);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL %s_model[%0d] got=%0d exp=%0d", name, k, $signed(got_q[k]), $signed(exp_q[k]));
      end
      if (k >= 2) begin
        tests++;
        if (got_q[k] !== OUT_W'(settled)) begin
          fails++;
          $display("FAIL %s_settled[%0d] got=%0d exp=%0d", name, k, $signed(got_q[k]), settled);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] held;
    int n_hold;
    int bad_rdy = 0;
    int bad_dat = 0;
    int budget = 4 * R;
    do_reset();
    @(posedge aclk); #1;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = IN_BW'(1);
    while (!m_if.tvalid && budget > 0) begin
      @(posedge aclk); #1;
      budget--;
    end
    tests++;
    if (!m_if.tvalid) begin fails++; $display("FAIL bp_output_pending got=0 exp=1"); end
    held   = m_if.tdata;
    n_hold = n_acc;
    repeat (50) begin
      @(negedge aclk);
      if (s_if.tready !== 1'b0) bad_rdy++;
      if (m_if.tdata !== held || m_if.tvalid !== 1'b1) bad_dat++;
    end
    @(posedge aclk); #1;
    tests += 3;
    if (bad_rdy != 0) begin fails++; $display("FAIL bp_tready_low bad_cycles=%0d exp=0", bad_rdy); end
    if (bad_dat != 0) begin fails++; $display("FAIL bp_tdata_stable bad_cycles=%0d exp=0", bad_dat); end
    if (n_acc != n_hold) begin fails++; $display("FAIL bp_no_accept got=%0d exp=%0d", n_acc, n_hold); end
    m_if.tready = 1'b1;
    @(negedge aclk);
    tests++;
    if (s_if.tready !== 1'b1) begin fails++; $display("FAIL bp_release_tready got=%b exp=1", s_if.tready); end
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
    drain();
    tests += 2;
    if (got_q.size() < 1 || got_q[0] !== OUT_W'(715)) begin
      fails++;
      $display("FAIL bp_held_value got=%0d exp=715", got_q.size() > 0 ? $signed(got_q[0]) : -1);
    end
    if (held !== OUT_W'(715)) begin fails++; $display("FAIL bp_held_data got=%0d exp=715", $signed(held)); end
    // random consumer stalls with random codes: nothing dropped or altered
    drive(20 * R, 1, 0, 80, 50);
    drain();
    tests++;
    if (got_q.size() != n_acc / R || exp_q.size() != n_acc / R) begin
      fails++;
      $display("FAIL bp_random_count got=%0d exp=%0d", got_q.size(), n_acc / R);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL bp_random[%0d] got=%0d exp=%0d", k, $signed(got_q[k]), $signed(exp_q[k]));
      end
    end
  endtask

  task automatic test_reset_mid_batch();
    logic [OUT_W-1:0] got;
    do_reset();
    drive(30, 0, 1, 100, 100);
    @(posedge aclk); #1 arst = 1'b1;
    @(negedge aclk);
    tests += 2;
    if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL mid_reset_tvalid got=%b exp=0", m_if.tvalid); end
    if (m_if.tdata !== '0) begin fails++; $display("FAIL mid_reset_tdata got=%h exp=0", m_if.tdata); end
    @(posedge aclk); #1 arst = 1'b0;
    drive(R - 1, 0, 1, 100, 100);
    drain();
    tests++;
    if (got_q.size() != 0) begin fails++; $display("FAIL mid_early_output got=%0d exp=0", got_q.size()); end
    drive(1, 0, 1, 100, 100);
    drain();
    got = (got_q.size() > 0) ? got_q[0] : 'x;
    tests += 2;
    if (got_q.size() != 1) begin fails++; $display("FAIL mid_count got=%0d exp=1", got_q.size()); end
    if (got !== OUT_W'(715)) begin fails++; $display("FAIL mid_value got=%0d exp=715", $signed(got)); end
  endtask

  task automatic test_random_gaps();
    do_reset();
    drive(30 * R, 1, 0, 60, 70);
    drain();
    tests++;
    if (got_q.size() != 30 || exp_q.size() != 30) begin
      fails++;
      $display("FAIL gaps_count got=%0d exp=30", got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL gaps[%0d] got=%0d exp=%0d", k, $signed(got_q[k]), $signed(exp_q[k]));
      end
    end
  endtask

  // impulse response of ORDER cascaded length-R boxcars
  task automatic build_model();
    longint tmp [0:L-1];
    int len = 1;
    for (int i = 0; i < L; i++) h[i] = 0;
    h[0] = 1;
    repeat (ORDER) begin
      for (int i = 0; i < L; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      len += R - 1;
      for (int i = 0; i < L; i++) h[i] = tmp[i];
    end
  endtask

  initial begin
    arst        = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = IN_BW'(7);
    m_if.tready = 1'b0;
    build_model();
    @(posedge aclk);
    @(posedge aclk); #1;
    test_reset();
    test_startup();
    test_constant("plus1", 1, 10 * R, 4096);
    test_constant("plus7", 7, 10 * R, 28672);
    test_constant("minus8", -8, 10 * R, -32768);
    test_constant("wrap", 7, 100 * R, 28672);
    test_backpressure();
    test_reset_mid_batch();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout time=%0t limit=5000000", $time);
    $fatal(1, "timeout");
  end

endmodule
